// File: rtl/img_pkg.sv
// img_pkg: shared counter widths, latency and stage bundle for
// the 3x3 window generator.
package img_pkg;

   localparam int H_DISP = 1280;
   localparam int V_DISP = 720;
   localparam int CNT_W_H = $clog2(H_DISP);
   localparam int CNT_W_V = $clog2(V_DISP);
   localparam int WIN_LAT = 2;

   typedef struct packed {
      logic               valid;
      logic [CNT_W_H-1:0] x;
      logic [CNT_W_V-1:0] y;
   } s1_t;

endpackage

// File: rtl/line_buffer_ram.sv
// line_buffer_ram: one-line pixel store, 1 write + 1 read port,
// synchronous read-before-write, 1-cycle read latency.
module line_buffer_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 1280,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 window with border flags.
// Define WIN3X3_EDGE_ZERO_EN to zero out-of-image window entries.
module window_3x3_gen
   import img_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int H_DISP     = 1280,
   parameter int V_DISP     = 720
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pre_img_vsync,
   input  logic                  pre_img_hsync,
   input  logic                  pre_img_valid,
   input  logic [DATA_WIDTH-1:0] pre_img_data,
   output logic                  matrix_img_vsync,
   output logic                  matrix_img_hsync,
   output logic                  matrix_img_valid,
   output logic                  matrix_top_edge_flag,
   output logic                  matrix_bottom_edge_flag,
   output logic                  matrix_left_edge_flag,
   output logic                  matrix_right_edge_flag,
   output logic [DATA_WIDTH-1:0] matrix_p11,
   output logic [DATA_WIDTH-1:0] matrix_p12,
   output logic [DATA_WIDTH-1:0] matrix_p13,
   output logic [DATA_WIDTH-1:0] matrix_p21,
   output logic [DATA_WIDTH-1:0] matrix_p22,
   output logic [DATA_WIDTH-1:0] matrix_p23,
   output logic [DATA_WIDTH-1:0] matrix_p31,
   output logic [DATA_WIDTH-1:0] matrix_p32,
   output logic [DATA_WIDTH-1:0] matrix_p33
);

   localparam int AW = $clog2(H_DISP);
   localparam logic [CNT_W_H-1:0] X_LAST = CNT_W_H'(H_DISP - 1);
   localparam logic [CNT_W_V-1:0] Y_LAST = CNT_W_V'(V_DISP - 1);

`ifdef WIN3X3_EDGE_ZERO_EN
   localparam bit EDGE_ZERO = 1'b1;
`else
   localparam bit EDGE_ZERO = 1'b0;
`endif

   logic               vs_q;
   logic               vs_rise;
   logic [CNT_W_H-1:0] x, bx;
   logic [CNT_W_V-1:0] y, by;

   s1_t                   s1;
   logic [DATA_WIDTH-1:0] pix_d1;
   logic [DATA_WIDTH-1:0] lb0_q, lb1_q;
   logic [DATA_WIDTH-1:0] col [3];
   logic [DATA_WIDTH-1:0] win [3][3];
   logic [DATA_WIDTH-1:0] nw  [3][3];
   logic [WIN_LAT-1:0]    vs_p, hs_p;

   // A vsync rising edge makes the current beat (0,0).
   always_comb begin
      vs_rise = pre_img_vsync & ~vs_q;
      bx = vs_rise ? '0 : x;
      by = vs_rise ? '0 : y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q <= 1'b0;
         x    <= '0;
         y    <= '0;
      end else begin
         vs_q <= pre_img_vsync;
         x    <= bx;
         y    <= by;
         if (pre_img_valid) begin
            if (bx == X_LAST) begin
               x <= '0;
               y <= (by == Y_LAST) ? '0 : by + 1'b1;
            end else begin
               x <= bx + 1'b1;
            end
         end
      end
   end

   line_buffer_ram #(
      .DW   (DATA_WIDTH),
      .DEPTH(H_DISP),
      .AW   (AW)
   ) u_lb0 (
      .clk    (clk),
      .we     (pre_img_valid),
      .wr_addr(bx[AW-1:0]),
      .wr_data(pre_img_data),
      .rd_addr(bx[AW-1:0]),
      .rd_data(lb0_q)
   );

   // lb1 takes lb0's old word one cycle later, at the same column.
   line_buffer_ram #(
      .DW   (DATA_WIDTH),
      .DEPTH(H_DISP),
      .AW   (AW)
   ) u_lb1 (
      .clk    (clk),
      .we     (s1.valid),
      .wr_addr(s1.x[AW-1:0]),
      .wr_data(lb0_q),
      .rd_addr(bx[AW-1:0]),
      .rd_data(lb1_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= '0;
         pix_d1 <= '0;
      end else begin
         s1.valid <= pre_img_valid;
         s1.x     <= bx;
         s1.y     <= by;
         pix_d1   <= pre_img_data;
      end
   end

   always_comb begin
      col[0] = lb1_q;
      col[1] = lb0_q;
      col[2] = pix_d1;
      for (int r = 0; r < 3; r++) begin
         nw[r][0] = win[r][1];
         nw[r][1] = win[r][2];
         nw[r][2] = col[r];
         for (int c = 0; c < 3; c++) begin
            if (EDGE_ZERO &&
                ((r == 0 && s1.y < 2) || (r == 1 && s1.y == 0) ||
                 (c == 0 && s1.x < 2) || (c == 1 && s1.x == 0)))
               nw[r][c] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
         vs_p                    <= '0;
         hs_p                    <= '0;
         matrix_img_valid        <= 1'b0;
         matrix_top_edge_flag    <= 1'b0;
         matrix_bottom_edge_flag <= 1'b0;
         matrix_left_edge_flag   <= 1'b0;
         matrix_right_edge_flag  <= 1'b0;
      end else begin
         if (s1.valid)
            win <= nw;
         vs_p                    <= {vs_p[WIN_LAT-2:0], pre_img_vsync};
         hs_p                    <= {hs_p[WIN_LAT-2:0], pre_img_hsync};
         matrix_img_valid        <= s1.valid;
         matrix_top_edge_flag    <= s1.valid & (s1.y < 2);
         matrix_bottom_edge_flag <= s1.valid & (s1.y == Y_LAST);
         matrix_left_edge_flag   <= s1.valid & (s1.x < 2);
         matrix_right_edge_flag  <= s1.valid & (s1.x == X_LAST);
      end
   end

   assign matrix_img_vsync = vs_p[WIN_LAT-1];
   assign matrix_img_hsync = hs_p[WIN_LAT-1];
   assign matrix_p11 = win[0][0];
   assign matrix_p12 = win[0][1];
   assign matrix_p13 = win[0][2];
   assign matrix_p21 = win[1][0];
   assign matrix_p22 = win[1][1];
   assign matrix_p23 = win[1][2];
   assign matrix_p31 = win[2][0];
   assign matrix_p32 = win[2][1];
   assign matrix_p33 = win[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed scoreboard bench for window_3x3_gen
// on an 8x6 image.
module tb_window_3x3_gen;

   localparam int H  = 8;
   localparam int V  = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pre_img_vsync, pre_img_hsync, pre_img_valid;
   logic [DW-1:0] pre_img_data;
   logic          matrix_img_vsync, matrix_img_hsync, matrix_img_valid;
   logic          f_top, f_bot, f_left, f_right;
   logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic [DW-1:0] win [9];

   window_3x3_gen #(
      .DATA_WIDTH(DW),
      .H_DISP    (H),
      .V_DISP    (V)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .pre_img_vsync          (pre_img_vsync),
      .pre_img_hsync          (pre_img_hsync),
      .pre_img_valid          (pre_img_valid),
      .pre_img_data           (pre_img_data),
      .matrix_img_vsync       (matrix_img_vsync),
      .matrix_img_hsync       (matrix_img_hsync),
      .matrix_img_valid       (matrix_img_valid),
      .matrix_top_edge_flag   (f_top),
      .matrix_bottom_edge_flag(f_bot),
      .matrix_left_edge_flag  (f_left),
      .matrix_right_edge_flag (f_right),
      .matrix_p11             (p11),
      .matrix_p12             (p12),
      .matrix_p13             (p13),
      .matrix_p21             (p21),
      .matrix_p22             (p22),
      .matrix_p23             (p23),
      .matrix_p31             (p31),
      .matrix_p32             (p32),
      .matrix_p33             (p33)
   );

   always #5 clk = ~clk;

   assign win[0] = p11;
   assign win[1] = p12;
   assign win[2] = p13;
   assign win[3] = p21;
   assign win[4] = p22;
   assign win[5] = p23;
   assign win[6] = p31;
   assign win[7] = p32;
   assign win[8] = p33;

   typedef struct {
      int            x;
      int            y;
      logic [DW-1:0] w [9];
      bit            m [9];
      bit            t, b, l, r;
   } exp_t;

   exp_t sb [$];

   int n_assert = 0;
   int n_fail   = 0;
   int img [V][H];
   int mx, my;
   bit mvs;
   logic [2:0] h1, h2;
   logic [DW-1:0] prev_win [9];
   bit prev_ok = 0;
   int c_top = 0, c_bot = 0, c_left = 0, c_right = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      chk("valid_dly", {31'b0, matrix_img_valid}, {31'b0, h2[0]});
      chk("hsync_dly", {31'b0, matrix_img_hsync}, {31'b0, h2[1]});
      chk("vsync_dly", {31'b0, matrix_img_vsync}, {31'b0, h2[2]});
      if (matrix_img_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("top(%0d,%0d)", e.x, e.y), {31'b0, f_top}, {31'b0, e.t});
            chk($sformatf("bot(%0d,%0d)", e.x, e.y), {31'b0, f_bot}, {31'b0, e.b});
            chk($sformatf("left(%0d,%0d)", e.x, e.y), {31'b0, f_left}, {31'b0, e.l});
            chk($sformatf("right(%0d,%0d)", e.x, e.y), {31'b0, f_right}, {31'b0, e.r});
            for (int k = 0; k < 9; k++)
               if (e.m[k])
                  chk($sformatf("p%0d%0d(%0d,%0d)", k / 3 + 1, k % 3 + 1, e.x, e.y),
                      {24'b0, win[k]}, {24'b0, e.w[k]});
            c_top   += int'(f_top);
            c_bot   += int'(f_bot);
            c_left  += int'(f_left);
            c_right += int'(f_right);
         end
      end else begin
         chk("flags_idle", {28'b0, f_top, f_bot, f_left, f_right}, 32'd0);
         if (prev_ok)
            for (int k = 0; k < 9; k++)
               chk($sformatf("hold_p%0d%0d", k / 3 + 1, k % 3 + 1),
                   {24'b0, win[k]}, {24'b0, prev_win[k]});
      end
      prev_win = win;
      prev_ok  = 1;
   endtask

   // One clock: check outputs, then drive the next input beat.
   task automatic step(input bit v, input bit vs, input int off);
      exp_t e;
      int   pix;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      h2 = h1;
      h1 = {pre_img_vsync, pre_img_hsync, pre_img_valid};
      #1;
      if (vs && !mvs) begin
         mx = 0;
         my = 0;
      end
      mvs = vs;
      pre_img_vsync = vs;
      pre_img_valid = v;
      pre_img_hsync = v && (mx == 0);
      if (v) begin
         pix = (8 * my + mx + off) % 256;
         pre_img_data = DW'(pix);
         img[my][mx] = pix;
         e.x = mx;
         e.y = my;
         e.t = (my < 2);
         e.b = (my == V - 1);
         e.l = (mx < 2);
         e.r = (mx == H - 1);
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               int px, py, k;
               px = mx - 2 + c;
               py = my - 2 + r;
               k  = r * 3 + c;
               if (px >= 0 && py >= 0) begin
                  e.w[k] = DW'(img[py][px]);
                  e.m[k] = 1;
               end else begin
                  e.w[k] = '0;
`ifdef WIN3X3_EDGE_ZERO_EN
                  e.m[k] = 1;
`else
                  e.m[k] = 0;
`endif
               end
            end
         sb.push_back(e);
         if (mx == H - 1) begin
            mx = 0;
            my = (my == V - 1) ? 0 : my + 1;
         end else begin
            mx = mx + 1;
         end
      end else begin
         pre_img_data = DW'($urandom);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctrl"},
          {25'b0, matrix_img_vsync, matrix_img_hsync, matrix_img_valid,
           f_top, f_bot, f_left, f_right}, 32'd0);
      chk({tag, "_win"},
          {31'b0, |{p11, p12, p13, p21, p22, p23, p31, p32, p33}}, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      pre_img_vsync = 1'b0;
      pre_img_hsync = 1'b0;
      pre_img_valid = 1'b0;
      pre_img_data  = '0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs("in_reset");
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      h1 = '0;
      h2 = '0;
      mx = 0;
      my = 0;
      mvs = 0;
      prev_ok = 0;
   endtask

   initial begin
      int t0, b0, l0, r0, n, guard;
      rst_n = 1'b0;
      pre_img_vsync = 1'b0;
      pre_img_hsync = 1'b0;
      pre_img_valid = 1'b0;
      pre_img_data  = '0;
      h1 = '0;
      h2 = '0;
      mx = 0;
      my = 0;
      mvs = 0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs("por");
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Frame 1: continuous ramp, per-frame flag counts.
      t0 = c_top; b0 = c_bot; l0 = c_left; r0 = c_right;
      step(0, 1, 0);
      repeat (H * V) step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      chk("top_count",   c_top - t0,   32'd16);
      chk("left_count",  c_left - l0,  32'd12);
      chk("right_count", c_right - r0, 32'd6);
      chk("bot_count",   c_bot - b0,   32'd8);

      // Frame 2: vsync with first beat, then ~50% valid gaps.
      step(1, 1, 0);
      n = 1;
      guard = 0;
      while (n < H * V && guard < 2000) begin
         bit v;
         v = 1'($urandom_range(0, 1));
         step(v, 0, 0);
         n += int'(v);
         guard++;
      end
      chk("gap_frame_done", n, H * V);
      repeat (3) step(0, 0, 0);

      // Frame 3: vsync restart mid-frame at (5,2).
      step(0, 1, 64);
      repeat (2 * H + 5) step(1, 0, 64);
      step(0, 1, 64);
      repeat (2 * H + 3) step(1, 0, 64);

      // Reset mid-line, misaligned beats, then a fresh frame.
      do_reset();
      repeat (3) step(1, 0, 128);
      step(0, 1, 128);
      repeat (2 * H + 2) step(1, 0, 128);
      repeat (4) step(0, 0, 128);

      chk("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
